// File: rtl/dmem_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic        PORT0      = 1'b0;
  localparam logic        PORT1      = 1'b1;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port that was not granted last wins.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req_i == 2'b11) begin
      gnt_o = (last_grant_i == PORT1) ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one combinational data memory between two requesters, one word access at a time,
// with registered strobes and a single-cycle ack back to the granted port.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - WORD_BYTES);

  state_e            state_q, state_d;
  logic              sel_q;
  logic              last_grant_q;
  logic              we_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic [1:0]        gnt;
  logic              any_req;
  logic              grant_port;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_legal;

  rr_arb2 u_rr_arb2 (
    .req_i        ({m1_req, m0_req}),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  assign any_req    = m0_req | m1_req;
  assign grant_port = gnt[1] ? PORT1 : PORT0;
  assign req_we     = (grant_port == PORT1) ? m1_we    : m0_we;
  assign req_addr   = (grant_port == PORT1) ? m1_addr  : m0_addr;
  assign req_wdata  = (grant_port == PORT1) ? m1_wdata : m0_wdata;
  assign req_legal  = (req_addr[1:0] == 2'b00) && (req_addr <= MAX_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = req_legal ? ACCESS : RESP;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_err   = 1'b0;
    m1_err   = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (state_q == RESP) begin
      if (sel_q == PORT1) begin
        m1_ack   = 1'b1;
        m1_err   = err_q;
        m1_rdata = rdata_q;
      end else begin
        m0_ack   = 1'b1;
        m0_err   = err_q;
        m0_rdata = rdata_q;
      end
    end
  end

  // Memory-side outputs are registers only, so the level-sensitive memory never sees a glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q        <= PORT0;
      last_grant_q <= PORT1;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            sel_q        <= grant_port;
            last_grant_q <= grant_port;
            we_q         <= req_we;
            err_q        <= ~req_legal;
            rdata_q      <= '0;
            if (req_legal) begin
              mem_addr_q  <= req_addr;
              mem_wdata_q <= req_we ? req_wdata : '0;
              mem_read_q  <= ~req_we;
              mem_write_q <= req_we;
            end
          end
        end
        ACCESS: begin
          if (!we_q) rdata_q <= mem_rdata;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
        RESP: begin
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule
